// File: rtl/ula_pkg.sv
// Shared definitions for the ULA request scheduler: opcodes, FSM states, id width.
package ula_pkg;

   localparam logic [3:0] OP_SOMA = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;

   localparam int ID_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } ula_state_t;

endpackage

// File: rtl/ula_rr_arb.sv
// Combinational round-robin arbiter: first pending request at or after ptr, wrapping.
module ula_rr_arb
   import ula_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   int cand;

   // Scan NREQ positions starting at ptr; the first hit wins and masks later ones.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/ula_sched.sv
// Time-shares one combinational ULA between NREQ requesters with round-robin arbitration.
// Optional ULA_OPCHECK_EN: opcodes with op[3:2]!=0 are answered with rsp_err=1 without using the ULA.
module ula_sched
   import ula_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int OW   = 8,
   parameter int HOLD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [OW-1:0]     rsp_data,
   output logic              rsp_err,
   output logic [3:0]        ula_switchs,
   output logic [W-1:0]      ula_a,
   output logic [W-1:0]      ula_b,
   input  logic [OW-1:0]     ula_saida
);

   ula_state_t      state, state_nx;
   logic [ID_W-1:0] ptr, g_r, gidx;
   logic [NREQ-1:0] grant;
   logic            gany;
   logic [3:0]      op_r, sel_op, cnt;
   logic [W-1:0]    a_r, b_r, sel_a, sel_b;
   logic            bad_op, last;

   ula_rr_arb #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   assign sel_op = req_op[int'(gidx)*4 +: 4];
   assign sel_a  = req_a[int'(gidx)*W +: W];
   assign sel_b  = req_b[int'(gidx)*W +: W];

   // One settle cycle after the operands appear, then HOLD cycles before capture.
   assign last = (cnt == 4'(HOLD));

`ifdef ULA_OPCHECK_EN
   assign bad_op = |sel_op[3:2];
`else
   assign bad_op = 1'b0;
`endif

   // Next state and the strobes that exist only in a given state.
   always_comb begin
      state_nx    = state;
      req_ready   = '0;
      rsp_valid   = 1'b0;
      ula_switchs = '0;
      ula_a       = '0;
      ula_b       = '0;
      case (state)
         IDLE: begin
            if (gany) begin
               req_ready = grant;
               state_nx  = bad_op ? RESP : EXEC;
            end
         end
         EXEC: begin
            ula_switchs = op_r;
            ula_a       = a_r;
            ula_b       = b_r;
            if (last) state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, round-robin pointer, operand latch, hold counter and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         g_r      <= '0;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         cnt      <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (gany) begin
                  op_r <= sel_op;
                  a_r  <= sel_a;
                  b_r  <= sel_b;
                  g_r  <= gidx;
                  cnt  <= '0;
                  ptr  <= (gidx == ID_W'(NREQ-1)) ? '0 : gidx + 1'b1;
                  if (bad_op) begin
                     rsp_id   <= gidx;
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  rsp_id   <= g_r;
                  rsp_data <= ula_saida;
                  rsp_err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
